// File: rtl/c16_audio_pkg.sv
// c16_audio_pkg: shared types and helpers for the C16 time-multiplexed audio mixer.
package c16_audio_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SCALE = 2'd2} mix_state_t;
  localparam int GAIN_SHIFT_DEF = 3;
  localparam int GAIN_UNITY = 1 << GAIN_SHIFT_DEF;
  typedef struct packed {
    logic signed [63:0] val;
    logic clip;
  } sat_t;
  function automatic sat_t sat_signed(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sat_t r;
    mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (out_w - 1));
    r.clip = (acc > mx) || (acc < mn);
    r.val = (acc > mx) ? mx : (acc < mn) ? mn : acc;
    return r;
  endfunction
  function automatic int ch_lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/c16_audio_mixer_sat_clip.sv
// c16_sat_clip: floor-shift the accumulator and saturate it to the DAC width.
module c16_sat_clip
  import c16_audio_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16,
  parameter int GAIN_SHIFT = 3
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sat,
  output logic                    clip
);
  logic signed [ACC_W-1:0] s;
  sat_t r;
  always_comb begin
    s = acc >>> GAIN_SHIFT;
    r = sat_signed(64'(s), OUT_W);
    sat = OUT_W'(r.val);
    clip = r.clip;
  end
endmodule

// File: rtl/c16_audio_mixer.sv
// c16_audio_mixer: per-channel gain/mute serial MAC mixer with saturating output and sticky status.
module c16_audio_mixer
  import c16_audio_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int IN_W = 17,
  parameter int OUT_W = 16,
  parameter int GAIN_W = 4,
  parameter int GAIN_SHIFT = 3,
  parameter int ACC_W = 24
) (
  input  logic                       CLK28,
  input  logic                       RESET,
  input  logic                       sample_ce,
  input  logic [CHANNELS*IN_W-1:0]   ch_data,
  input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
  input  logic [CHANNELS-1:0]        ch_mute,
  input  logic                       status_clr,
  output logic signed [OUT_W-1:0]    sound,
  output logic                       sound_valid,
  output logic                       busy,
  output logic                       clip,
  output logic                       overrun
);
  localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;
  if (ACC_W < IN_W + GAIN_W + $clog2(CHANNELS) + 1) begin : g_acc_chk
    $error("ACC_W too narrow for IN_W, GAIN_W and CHANNELS");
  end
  mix_state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, term;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CHANNELS*IN_W-1:0] data_q, data_d;
  logic [CHANNELS*GAIN_W-1:0] gain_q, gain_d;
  logic [CHANNELS-1:0] mute_q, mute_d;
  logic signed [OUT_W-1:0] sound_q, sound_d, sat_val;
  logic valid_q, valid_d, clip_q, clip_d, overrun_q, overrun_d, sat_clip;
  logic [IN_W-1:0] cur_data;
  logic [GAIN_W-1:0] cur_gain;
  logic signed [PROD_W-1:0] data_x, gain_x, prod;
  logic idle, start, last, scale;
  c16_sat_clip #(.ACC_W(ACC_W), .OUT_W(OUT_W), .GAIN_SHIFT(GAIN_SHIFT)) u_sat (
    .acc (acc_q),
    .sat (sat_val),
    .clip(sat_clip)
  );
  always_comb begin
    idle = state_q == IDLE;
    start = idle & sample_ce;
    last = idx_q == IDX_W'(CHANNELS - 1);
    scale = state_q == SCALE;
    cur_data = data_q[ch_lsb(int'(idx_q), IN_W) +: IN_W];
    cur_gain = gain_q[ch_lsb(int'(idx_q), GAIN_W) +: GAIN_W];
    data_x = PROD_W'($signed(cur_data));
    gain_x = PROD_W'({1'b0, cur_gain});
    prod = data_x * gain_x;
    term = mute_q[idx_q] ? '0 : ACC_W'(prod);
    state_d = start ? ACCUM : (state_q == ACCUM && last) ? SCALE : scale ? IDLE : state_q;
    acc_d = start ? '0 : (state_q == ACCUM) ? acc_q + term : acc_q;
    idx_d = start ? '0 : (state_q == ACCUM) ? idx_q + 1'b1 : idx_q;
    data_d = start ? ch_data : data_q;
    gain_d = start ? ch_gain : gain_q;
    mute_d = start ? ch_mute : mute_q;
    sound_d = scale ? sat_val : sound_q;
    valid_d = scale;
    // a fresh event outranks a simultaneous clear
    clip_d = (scale & sat_clip) | (clip_q & ~status_clr);
    overrun_d = (sample_ce & ~idle) | (overrun_q & ~status_clr);
  end
  always_ff @(posedge CLK28) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      gain_q <= '0;
      mute_q <= '0;
      sound_q <= '0;
      valid_q <= 1'b0;
      clip_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      data_q <= data_d;
      gain_q <= gain_d;
      mute_q <= mute_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
      clip_q <= clip_d;
      overrun_q <= overrun_d;
    end
  end
  assign sound = sound_q;
  assign sound_valid = valid_q;
  assign busy = ~idle;
  assign clip = clip_q;
  assign overrun = overrun_q;
endmodule
